// File: rtl/axi_compare_pkg.sv
// rtl/axi_compare_pkg.sv - shared types and bit voter for the N-way AXI response comparator
package axi_compare_pkg;

    localparam int unsigned MaxBus = 16;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } axi_r_t;

    // Per-cycle events raised by a channel: a mismatching pop and the skew timer hitting its limit
    typedef struct packed {
        logic mismatch;
        logic timeout;
    } chan_evt_t;

    // Strict majority over the low n bits of a column
    function automatic logic majority(input logic [MaxBus-1:0] bits, input int unsigned n);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < MaxBus; i++) begin
            if (i < n) ones = ones + {31'b0, bits[i]};
        end
        return ((ones << 1) > n);
    endfunction

endpackage

// File: rtl/axi_resp_compare_chan.sv
// rtl/axi_resp_compare_chan.sv - one response channel: per-bus FIFOs, voter, comparator, counter, skew timer
module axi_resp_compare_chan
    import axi_compare_pkg::*;
#(
    parameter int unsigned NumBus        = 2,
    parameter int unsigned FifoDepth     = 16,
    parameter bit          Vote          = 1'b0,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = 16,
    parameter type         chan_t        = axi_b_t
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  chan_t [NumBus-1:0]  in_i,
    input  logic  [NumBus-1:0]  in_valid_i,
    output logic  [NumBus-1:0]  in_ready_o,
    output chan_t               out_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic  [NumBus-1:0]  mismatch_o,
    output logic  [CntWidth-1:0] mismatch_cnt_o,
    output logic                timeout_o,
    output logic                busy_o
);
    localparam int unsigned W  = $bits(chan_t);
    localparam int unsigned TW = $clog2(TimeoutCycles + 2);

    logic [W-1:0]      head [NumBus];
    logic [NumBus-1:0] full, empty, diff;
    logic [W-1:0]      ref_beat;
    logic              pop, skew_now;
    logic [TW-1:0]     skew_q;
    chan_evt_t         evt;

    for (genvar i = 0; i < NumBus; i++) begin : g_fifo
        assign in_ready_o[i] = !full[i] && !rst_i;
        fifo_v3 #(.Width(W), .Depth(FifoDepth)) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (in_valid_i[i] && in_ready_o[i]),
            .data_i  (in_i[i]),
            .pop_i   (pop),
            .data_o  (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    assign out_valid_o = ~|empty;
    assign pop         = out_valid_o && out_ready_i;
    assign busy_o      = ~&empty;
    assign skew_now    = (|empty) && (~&empty);
    assign out_o       = out_valid_o ? chan_t'(ref_beat) : '0;

    // Reference beat: bus 0's head, or the per-bit majority across all heads
    always_comb begin
        logic [MaxBus-1:0] col;
        col      = '0;
        ref_beat = head[0];
        if (Vote) begin
            for (int unsigned k = 0; k < W; k++) begin
                col = '0;
                for (int unsigned i = 0; i < NumBus; i++) col[i] = head[i][k];
                ref_beat[k] = majority(col, NumBus);
            end
        end
    end

    // Whole-beat comparison of every bus against the reference
    always_comb begin
        diff = '0;
        for (int unsigned i = 0; i < NumBus; i++) diff[i] = (head[i] != ref_beat);
    end

    assign evt.mismatch = pop && (|diff);
    assign evt.timeout  = (TimeoutCycles != 0) && skew_now && (skew_q == TW'(TimeoutCycles - 1));

    // Mismatch pulse, saturating counter, skew timer and sticky timeout; clear wins over same-cycle events
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mismatch_o     <= '0;
            mismatch_cnt_o <= '0;
            skew_q         <= '0;
            timeout_o      <= 1'b0;
        end else begin
            mismatch_o <= pop ? diff : '0;
            if (clr_i) begin
                mismatch_cnt_o <= '0;
                skew_q         <= '0;
                timeout_o      <= 1'b0;
            end else begin
                if (evt.mismatch && (mismatch_cnt_o != '1)) mismatch_cnt_o <= mismatch_cnt_o + CntWidth'(1);
                if ((TimeoutCycles == 0) || !skew_now) skew_q <= '0;
                else if (skew_q != TW'(TimeoutCycles)) skew_q <= skew_q + TW'(1);
                if (evt.timeout) timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_v3.sv
// rtl/fifo_v3.sv - registered-output FIFO without fall-through, async active-high reset
module fifo_v3 #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rptr_q];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= (wptr_q == AW'(Depth - 1)) ? '0 : wptr_q + AW'(1);
            if (do_pop)  rptr_q <= (rptr_q == AW'(Depth - 1)) ? '0 : rptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr_q] <= data_i;
    end

endmodule

// File: rtl/axi_resp_compare_n.sv
// rtl/axi_resp_compare_n.sv - N-way lockstep comparator for AXI B and R response channels
module axi_resp_compare_n
    import axi_compare_pkg::*;
#(
    parameter int unsigned NumBus        = 2,
    parameter int unsigned FifoDepth     = 16,
    parameter bit          Vote          = 1'b0,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntWidth      = 16,
    parameter type         b_chan_t      = axi_b_t,
    parameter type         r_chan_t      = axi_r_t
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  b_chan_t [NumBus-1:0]  b_i,
    input  logic    [NumBus-1:0]  b_valid_i,
    output logic    [NumBus-1:0]  b_ready_o,
    input  r_chan_t [NumBus-1:0]  r_i,
    input  logic    [NumBus-1:0]  r_valid_i,
    output logic    [NumBus-1:0]  r_ready_o,
    output b_chan_t               b_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output r_chan_t               r_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic    [NumBus-1:0]  b_mismatch_o,
    output logic    [NumBus-1:0]  r_mismatch_o,
    output logic    [CntWidth-1:0] b_mismatch_cnt_o,
    output logic    [CntWidth-1:0] r_mismatch_cnt_o,
    output logic    [1:0]         timeout_o,
    output logic                  busy_o
);
    logic b_busy, r_busy, b_timeout, r_timeout;

    axi_resp_compare_chan #(
        .NumBus(NumBus), .FifoDepth(FifoDepth), .Vote(Vote),
        .TimeoutCycles(TimeoutCycles), .CntWidth(CntWidth), .chan_t(b_chan_t)
    ) u_b (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .in_i(b_i), .in_valid_i(b_valid_i), .in_ready_o(b_ready_o),
        .out_o(b_o), .out_valid_o(b_valid_o), .out_ready_i(b_ready_i),
        .mismatch_o(b_mismatch_o), .mismatch_cnt_o(b_mismatch_cnt_o),
        .timeout_o(b_timeout), .busy_o(b_busy)
    );

    axi_resp_compare_chan #(
        .NumBus(NumBus), .FifoDepth(FifoDepth), .Vote(Vote),
        .TimeoutCycles(TimeoutCycles), .CntWidth(CntWidth), .chan_t(r_chan_t)
    ) u_r (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .in_i(r_i), .in_valid_i(r_valid_i), .in_ready_o(r_ready_o),
        .out_o(r_o), .out_valid_o(r_valid_o), .out_ready_i(r_ready_i),
        .mismatch_o(r_mismatch_o), .mismatch_cnt_o(r_mismatch_cnt_o),
        .timeout_o(r_timeout), .busy_o(r_busy)
    );

    assign busy_o    = b_busy | r_busy;
    assign timeout_o = {r_timeout, b_timeout};

endmodule

// File: tb/tb_axi_resp_compare_n.sv
// tb/tb_axi_resp_compare_n.sv - self-checking bench for axi_resp_compare_n
module tb_axi_resp_compare_n;
    import axi_compare_pkg::*;

    localparam int NB    = 3;
    localparam int DEPTH = 2;
    localparam int TC    = 4;
    localparam int CW    = 2;
    localparam bit VOTE  = 1'b1;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic clr_i = 1'b0;
    axi_b_t [NB-1:0] b_i = '0;
    axi_r_t [NB-1:0] r_i = '0;
    logic [NB-1:0] b_valid_i = '0, r_valid_i = '0, b_ready_o, r_ready_o;
    axi_b_t b_o;
    axi_r_t r_o;
    logic b_valid_o, r_valid_o;
    logic b_ready_i = 1'b1, r_ready_i = 1'b1;
    logic [NB-1:0] b_mismatch_o, r_mismatch_o;
    logic [CW-1:0] b_mismatch_cnt_o, r_mismatch_cnt_o;
    logic [1:0] timeout_o;
    logic busy_o;

    int n_cmp = 0, n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: one queue per channel per bus, holding beats as plain vectors
    logic [63:0]   q [2][NB][$];
    logic [NB-1:0] m_mis [2];
    logic [NB-1:0] acc [2];
    int            m_cnt [2];
    int            m_skew [2];
    logic [1:0]    m_to;
    int            n_rpop;
    int            idx [2][NB];

    axi_resp_compare_n #(
        .NumBus(NB), .FifoDepth(DEPTH), .Vote(VOTE), .TimeoutCycles(TC), .CntWidth(CW),
        .b_chan_t(axi_b_t), .r_chan_t(axi_r_t)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
        .b_i(b_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .r_i(r_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
        .b_o(b_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .r_o(r_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .b_mismatch_o(b_mismatch_o), .r_mismatch_o(r_mismatch_o),
        .b_mismatch_cnt_o(b_mismatch_cnt_o), .r_mismatch_cnt_o(r_mismatch_cnt_o),
        .timeout_o(timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Majority of the bus heads, bit by bit (bus 0 when voting is off)
    function automatic logic [63:0] vote(input logic [63:0] h [NB]);
        logic [63:0] v;
        int ones;
        if (!VOTE) return h[0];
        for (int k = 0; k < 64; k++) begin
            ones = 0;
            for (int i = 0; i < NB; i++) ones += int'(h[i][k]);
            v[k] = (2 * ones > NB);
        end
        return v;
    endfunction

    // Beat k of a response sequence, as the raw struct bits
    function automatic logic [63:0] gen(input int c, input int k);
        logic [31:0] kk;
        kk = k;
        if (c == 0) return {57'b0, kk[3:0], kk[5:4], kk[6]};
        return {24'b0, kk[3:0], kk * 32'h9E3779B1, kk[5:4], kk[2], kk[6]};
    endfunction

    task automatic drive(input int c, input int i, input logic [63:0] v, input logic vld);
        if (c == 0) begin
            b_i[i] = axi_b_t'(v[6:0]);
            b_valid_i[i] = vld;
        end else begin
            r_i[i] = axi_r_t'(v[39:0]);
            r_valid_i[i] = vld;
        end
    endtask

    // Model update at each active edge from the inputs presented before it
    always @(posedge clk) begin
        if (rst_i) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < NB; i++) q[c][i].delete();
                m_mis[c] = '0; acc[c] = '0; m_cnt[c] = 0; m_skew[c] = 0;
            end
            m_to = '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                logic [63:0] h [NB];
                logic [63:0] refb;
                logic [NB-1:0] d;
                bit all_ne, any_ne, pop, vld;
                all_ne = 1'b1; any_ne = 1'b0; d = '0;
                for (int i = 0; i < NB; i++) begin
                    all_ne &= (q[c][i].size() != 0);
                    any_ne |= (q[c][i].size() != 0);
                end
                pop = all_ne && ((c == 0) ? b_ready_i : r_ready_i);
                if (pop) begin
                    for (int i = 0; i < NB; i++) h[i] = q[c][i][0];
                    refb = vote(h);
                    for (int i = 0; i < NB; i++) d[i] = (h[i] != refb);
                end
                m_mis[c] = d;
                if (clr_i) begin
                    m_cnt[c] = 0; m_skew[c] = 0; m_to[c] = 1'b0;
                end else begin
                    if (pop && d != 0 && m_cnt[c] < (1 << CW) - 1) m_cnt[c]++;
                    if (any_ne && !all_ne) begin
                        if (m_skew[c] < TC) m_skew[c]++;
                        if (m_skew[c] == TC) m_to[c] = 1'b1;
                    end else m_skew[c] = 0;
                end
                for (int i = 0; i < NB; i++) begin
                    vld = (c == 0) ? b_valid_i[i] : r_valid_i[i];
                    acc[c][i] = vld && (q[c][i].size() < DEPTH);
                end
                if (pop) for (int i = 0; i < NB; i++) void'(q[c][i].pop_front());
                for (int i = 0; i < NB; i++)
                    if (acc[c][i]) q[c][i].push_back((c == 0) ? 64'(b_i[i]) : 64'(r_i[i]));
                if (c == 1 && pop) n_rpop++;
            end
        end
    end

    // Compare every DUT output against the model once per cycle
    always @(negedge clk) begin
        if (chk_en) begin
            bit any;
            any = 1'b0;
            for (int c = 0; c < 2; c++) begin
                logic [63:0] h [NB];
                logic [NB-1:0] er;
                logic ev;
                ev = !rst_i;
                for (int i = 0; i < NB; i++) begin
                    er[i] = !rst_i && (q[c][i].size() < DEPTH);
                    ev &= (q[c][i].size() != 0);
                    any |= (q[c][i].size() != 0);
                    h[i] = (q[c][i].size() != 0) ? q[c][i][0] : 64'b0;
                end
                chk(c ? "r_ready" : "b_ready", c ? 64'(r_ready_o) : 64'(b_ready_o), 64'(er));
                chk(c ? "r_valid" : "b_valid", c ? 64'(r_valid_o) : 64'(b_valid_o), 64'(ev));
                if (ev) chk(c ? "r_data" : "b_data", c ? 64'(r_o) : 64'(b_o), vote(h));
                chk(c ? "r_mismatch" : "b_mismatch", c ? 64'(r_mismatch_o) : 64'(b_mismatch_o),
                    rst_i ? 64'b0 : 64'(m_mis[c]));
                chk(c ? "r_cnt" : "b_cnt", c ? 64'(r_mismatch_cnt_o) : 64'(b_mismatch_cnt_o),
                    rst_i ? 64'b0 : 64'(m_cnt[c]));
            end
            chk("timeout", 64'(timeout_o), rst_i ? 64'b0 : 64'(m_to));
            chk("busy", 64'(busy_o), 64'(any && !rst_i));
        end
    end

    initial begin
        logic [63:0] base;
        // Reset state
        repeat (2) tick();
        chk_en = 1'b1;
        chk("rst_busy", 64'(busy_o), 0);
        chk("rst_b_valid", 64'(b_valid_o), 0);
        chk("rst_r_ready", 64'(r_ready_o), 0);
        chk("rst_timeout", 64'(timeout_o), 0);
        rst_i = 1'b0;
        tick();
        chk("b_ready_after_rst", 64'(b_ready_o), 64'h7);

        // Aligned clean B beat id=5, OKAY
        for (int i = 0; i < NB; i++) drive(0, i, {57'b0, 4'd5, 2'b00, 1'b0}, 1'b1);
        tick();
        b_valid_i = '0;
        chk("b_clean_valid", 64'(b_valid_o), 1);
        chk("b_clean_id", 64'(b_o.id), 5);
        tick();
        chk("b_clean_mismatch", 64'(b_mismatch_o), 0);
        chk("b_clean_cnt", 64'(b_mismatch_cnt_o), 0);

        // Voting: bus 1 data bit 3 flipped
        for (int i = 0; i < NB; i++) drive(1, i, {24'b0, 4'd2, 32'hA5A5_0000, 2'b00, 1'b1, 1'b0}, 1'b1);
        r_i[1].data = r_i[1].data ^ 32'h8;
        tick();
        r_valid_i = '0;
        chk("vote_valid", 64'(r_valid_o), 1);
        chk("vote_data", 64'(r_o.data), 64'hA5A5_0000);
        tick();
        chk("vote_mismatch", 64'(r_mismatch_o), 64'b010);
        chk("vote_cnt", 64'(r_mismatch_cnt_o), 1);
        tick();
        chk("vote_pulse_end", 64'(r_mismatch_o), 0);

        // Four more mismatching pops saturate a 2-bit counter
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NB; i++) drive(1, i, gen(1, k), 1'b1);
            r_i[2].data[0] = ~r_i[2].data[0];
            tick();
        end
        r_valid_i = '0;
        repeat (2) tick();
        chk("sat_cnt", 64'(r_mismatch_cnt_o), 3);

        // Clear, then clear coinciding with a mismatching pop
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        chk("clr_cnt", 64'(r_mismatch_cnt_o), 0);
        for (int i = 0; i < NB; i++) drive(1, i, gen(1, 9), 1'b1);
        r_i[0].id = ~r_i[0].id;
        tick();
        r_valid_i = '0;
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        chk("clr_prio_cnt", 64'(r_mismatch_cnt_o), 0);
        tick();
        chk("clr_prio_cnt_hold", 64'(r_mismatch_cnt_o), 0);

        // Skew: bus 2's 8-beat R burst starts 8 cycles late
        n_rpop = 0;
        for (int i = 0; i < NB; i++) idx[1][i] = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            for (int i = 0; i < NB; i++) begin
                logic [63:0] v;
                v = gen(1, idx[1][i]);
                v[1] = (idx[1][i] == 7);
                drive(1, i, v, (cyc >= ((i == 2) ? 8 : 0)) && (idx[1][i] < 8));
            end
            tick();
            for (int i = 0; i < NB; i++) if (acc[1][i]) idx[1][i]++;
            if (cyc == 3) chk("skew_timeout_before", 64'(timeout_o[1]), 0);
            if (cyc == 4) chk("skew_timeout_set", 64'(timeout_o[1]), 1);
            if (cyc == 7) chk("skew_valid_before", 64'(r_valid_o), 0);
            if (cyc == 8) chk("skew_valid_first", 64'(r_valid_o), 1);
        end
        r_valid_i = '0;
        chk("skew_pops", 64'(n_rpop), 8);

        // Backpressure with depth 2
        r_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NB; i++) drive(1, i, gen(1, k), 1'b1);
            tick();
            if (k == 0) chk("bp_ready_one", 64'(r_ready_o), 64'h7);
            if (k == 1) chk("bp_ready_full", 64'(r_ready_o), 0);
        end
        r_valid_i = '0;
        r_ready_i = 1'b1;
        repeat (4) tick();

        // Randomized traffic
        for (int c = 0; c < 2; c++) for (int i = 0; i < NB; i++) idx[c][i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                for (int i = 0; i < NB; i++) begin
                    logic [63:0] v;
                    v = gen(c, idx[c][i]);
                    if ($urandom_range(9) == 0) v[$urandom_range(c ? 39 : 6)] ^= 1'b1;
                    drive(c, i, v, $urandom_range(9) < 7);
                end
            end
            b_ready_i = ($urandom_range(4) != 0);
            r_ready_i = ($urandom_range(4) != 0);
            clr_i = ($urandom_range(63) == 0);
            tick();
            for (int c = 0; c < 2; c++) for (int i = 0; i < NB; i++) if (acc[c][i]) idx[c][i]++;
        end
        b_valid_i = '0; r_valid_i = '0; clr_i = 1'b0;
        b_ready_i = 1'b1; r_ready_i = 1'b1;
        repeat (4) tick();

        // Reset with buffered beats discards them
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        for (int i = 0; i < NB; i++) begin
            drive(1, i, gen(1, 1), 1'b1);
            drive(0, i, gen(0, 1), 1'b1);
        end
        tick();
        b_valid_i = '0;
        tick();
        r_valid_i = '0;
        chk("pre_rst_busy", 64'(busy_o), 1);
        rst_i = 1'b1;
        #1;
        chk("async_rst_busy", 64'(busy_o), 0);
        chk("async_rst_r_valid", 64'(r_valid_o), 0);
        tick();
        chk("rst_edge_b_valid", 64'(b_valid_o), 0);
        rst_i = 1'b0;
        b_ready_i = 1'b1; r_ready_i = 1'b1;
        repeat (2) tick();
        chk("post_rst_busy", 64'(busy_o), 0);
        chk("post_rst_r_valid", 64'(r_valid_o), 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
